// File: rtl/pwm_bank_pkg.sv
// Shared constants and types for the four-channel PWM/timebase bank.
package pwm_bank_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 28;

  typedef logic [CNT_W-1:0] cnt_t;

  // A channel runs whenever its active period is non-zero.
  typedef enum logic {
    CH_IDLE,
    CH_RUN
  } ch_state_e;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: commit edge detect, pending/active period-compare pair,
// period counter and registered PWM output.
module pwm_chan
  import pwm_bank_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] period_i,
  input  logic [WIDTH-1:0] decode_i,
  input  logic             commit_i,
  input  logic             enable_i,
  output logic             pwm_o,
  output logic             period_end_o,
  output logic             pending_o
);

  logic             commit_q, commit_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] dec_q, dec_d;
  logic [WIDTH-1:0] pper_q, pper_d;
  logic [WIDTH-1:0] pdec_q, pdec_d;
  logic             pend_q, pend_d;
  logic             pwm_q, pwm_d;

  ch_state_e        state;
  logic             commit_edge;
  logic             wrap;

  // Register all channel state; reset returns the channel to idle and drops any pending pair.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      commit_q <= 1'b0;
      cnt_q    <= '0;
      per_q    <= '0;
      dec_q    <= '0;
      pper_q   <= '0;
      pdec_q   <= '0;
      pend_q   <= 1'b0;
      pwm_q    <= 1'b0;
    end else begin
      commit_q <= commit_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      dec_q    <= dec_d;
      pper_q   <= pper_d;
      pdec_q   <= pdec_d;
      pend_q   <= pend_d;
      pwm_q    <= pwm_d;
    end
  end

  // Decode channel state, commit edge and the last cycle of the period.
  always_comb begin
    state       = (per_q == '0) ? CH_IDLE : CH_RUN;
    commit_edge = commit_i & ~commit_q;
    wrap        = (state == CH_RUN) && enable_i && (cnt_q == per_q - 1'b1);
  end

  // Next-state: count, apply the pending pair at the boundary, capture new commits.
  always_comb begin
    commit_d = commit_i;
    cnt_d    = cnt_q;
    per_d    = per_q;
    dec_d    = dec_q;
    pper_d   = pper_q;
    pdec_d   = pdec_q;
    pend_d   = pend_q;

    unique case (state)
      CH_IDLE: begin
        if (pend_q) begin
          per_d  = pper_q;
          dec_d  = pdec_q;
          pend_d = 1'b0;
          cnt_d  = '0;
        end
      end
      CH_RUN: begin
        if (enable_i) begin
          if (wrap) begin
            cnt_d = '0;
            if (pend_q) begin
              per_d  = pper_q;
              dec_d  = pdec_q;
              pend_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase

    // A commit edge coinciding with a boundary lands in pending, after the old pair was applied.
    if (commit_edge) begin
      pper_d = period_i;
      pdec_d = decode_i;
      pend_d = 1'b1;
    end

    // PWM is computed from next-state so the register lines up with cnt/active of its cycle.
    pwm_d = (per_d != '0) && (cnt_d < dec_d);
  end

  // Drive channel outputs.
  always_comb begin
    pwm_o        = pwm_q;
    pending_o    = pend_q;
    period_end_o = wrap;
  end

endmodule

// File: rtl/pwm_bank_ctrl.sv
// Four-channel double-buffered PWM/timebase bank fed by the PIO period and
// decode registers.
module pwm_bank_ctrl #(
  parameter int unsigned NUM_CH = pwm_bank_pkg::NUM_CH,
  parameter int unsigned CNT_W  = pwm_bank_pkg::CNT_W
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [NUM_CH*CNT_W-1:0] period_i,
  input  logic [NUM_CH*CNT_W-1:0] decode_i,
  input  logic [NUM_CH-1:0]       commit_i,
  input  logic                    enable_i,
  output logic [NUM_CH-1:0]       pwm_o,
  output logic [NUM_CH-1:0]       period_end_o,
  output logic [NUM_CH-1:0]       pending_o
);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    pwm_chan #(
      .WIDTH(CNT_W)
    ) u_chan (
      .clk_i       (clk_clk),
      .rst_ni      (reset_reset_n),
      .period_i    (period_i[n*CNT_W +: CNT_W]),
      .decode_i    (decode_i[n*CNT_W +: CNT_W]),
      .commit_i    (commit_i[n]),
      .enable_i    (enable_i),
      .pwm_o       (pwm_o[n]),
      .period_end_o(period_end_o[n]),
      .pending_o   (pending_o[n])
    );
  end

endmodule

// File: tb/tb_pwm_bank_ctrl.sv
// Bench for pwm_bank_ctrl: per-cycle comparison against a period/duty model
// plus literal waveform measurements.
module tb_pwm_bank_ctrl;

  localparam int NCH = 4;
  localparam int W   = 28;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH*W-1:0]     period_i;
  logic [NCH*W-1:0]     decode_i;
  logic [NCH-1:0]       commit_i;
  logic                 enable_i;
  logic [NCH-1:0]       pwm_o;
  logic [NCH-1:0]       pe_o;
  logic [NCH-1:0]       pend_o;

  int checks   = 0;
  int failures = 0;

  pwm_bank_ctrl #(
    .NUM_CH(NCH),
    .CNT_W (W)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .period_i     (period_i),
    .decode_i     (decode_i),
    .commit_i     (commit_i),
    .enable_i     (enable_i),
    .pwm_o        (pwm_o),
    .period_end_o (pe_o),
    .pending_o    (pend_o)
  );

  always #5 clk = ~clk;

  // Model: position within the current period, active and queued (period, duty).
  int unsigned m_per [NCH] = '{default: 0};
  int unsigned m_duty[NCH] = '{default: 0};
  int unsigned m_qper[NCH] = '{default: 0};
  int unsigned m_qdut[NCH] = '{default: 0};
  int unsigned m_pos [NCH] = '{default: 0};
  bit          m_q   [NCH] = '{default: 0};
  bit          m_lvl [NCH] = '{default: 0};

  task automatic model_reset();
    for (int n = 0; n < NCH; n++) begin
      m_per[n] = 0; m_duty[n] = 0; m_qper[n] = 0; m_qdut[n] = 0;
      m_pos[n] = 0; m_q[n] = 0; m_lvl[n] = 0;
    end
  endtask

  task automatic model_step();
    for (int n = 0; n < NCH; n++) begin
      bit rise;
      rise     = commit_i[n] && !m_lvl[n];
      m_lvl[n] = commit_i[n];
      if (m_per[n] == 0) begin
        if (m_q[n]) begin
          m_per[n] = m_qper[n]; m_duty[n] = m_qdut[n]; m_q[n] = 0; m_pos[n] = 0;
        end
      end else if (enable_i) begin
        m_pos[n] = (m_pos[n] + 1) % m_per[n];
        if (m_pos[n] == 0 && m_q[n]) begin
          m_per[n] = m_qper[n]; m_duty[n] = m_qdut[n]; m_q[n] = 0;
        end
      end
      if (rise) begin
        m_qper[n] = int'(period_i[n*W +: W]);
        m_qdut[n] = int'(decode_i[n*W +: W]);
        m_q[n]    = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else        model_step();
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    for (int n = 0; n < NCH; n++) begin
      bit e_pwm, e_pe;
      e_pwm = (m_per[n] != 0) && (m_pos[n] < m_duty[n]);
      e_pe  = enable_i && (m_per[n] != 0) && (m_pos[n] == m_per[n] - 1);
      chk($sformatf("pwm_ch%0d", n), int'(pwm_o[n]), int'(e_pwm));
      chk($sformatf("period_end_ch%0d", n), int'(pe_o[n]), int'(e_pe));
      chk($sformatf("pending_ch%0d", n), int'(pend_o[n]), int'(m_q[n]));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic commit(input int ch, input int unsigned p, input int unsigned d);
    period_i[ch*W +: W] = W'(p);
    decode_i[ch*W +: W] = W'(d);
    commit_i[ch] = 1'b1;
    tick(1);
    commit_i[ch] = 1'b0;
  endtask

  task automatic count(input int ch, input int n, output int hi, output int pe);
    hi = 0; pe = 0;
    repeat (n) begin
      if (pwm_o[ch]) hi++;
      if (pe_o[ch])  pe++;
      tick(1);
    end
  endtask

  task automatic wait_pend_clear(input int ch, output int k);
    k = 0;
    while (pend_o[ch] && k < 40) begin
      tick(1);
      k++;
    end
    chk("pending_timeout", int'(pend_o[ch]), 0);
  endtask

  task automatic wait_pe(input int ch);
    int k;
    k = 0;
    while (!pe_o[ch] && k < 40) begin
      tick(1);
      k++;
    end
    chk("period_end_timeout", int'(pe_o[ch]), 1);
  endtask

  initial begin
    int hi, pe, k, bad;
    rst_n    = 1'b0;
    period_i = '0;
    decode_i = '0;
    commit_i = '0;
    enable_i = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("reset_pwm", int'(pwm_o), 0);
    chk("reset_pending", int'(pend_o), 0);
    chk("reset_period_end", int'(pe_o), 0);

    // ch0: P=10, D=3 from idle
    commit(0, 10, 3);
    chk("ch0_pending_set", int'(pend_o[0]), 1);
    tick(1);
    chk("ch0_pending_clr", int'(pend_o[0]), 0);
    chk("ch0_first_high", int'(pwm_o[0]), 1);
    count(0, 20, hi, pe);
    chk("ch0_high_cycles", hi, 6);
    chk("ch0_period_ends", pe, 2);

    // ch1: P=8, D=4, retuned mid-period to P=5, D=1
    commit(1, 8, 4);
    tick(1);
    count(1, 8, hi, pe);
    chk("ch1_old_high", hi, 4);
    chk("ch1_old_pe", pe, 1);
    tick(3);
    commit(1, 5, 1);
    chk("ch1_pending_set", int'(pend_o[1]), 1);
    wait_pend_clear(1, k);
    chk("ch1_pending_len", k, 4);
    count(1, 10, hi, pe);
    chk("ch1_new_high", hi, 2);
    chk("ch1_new_pe", pe, 2);

    // ch2: two commits before the boundary, only the last applies
    commit(2, 20, 1);
    tick(3);
    commit(2, 6, 2);
    tick(1);
    commit(2, 4, 3);
    wait_pend_clear(2, k);
    count(2, 8, hi, pe);
    chk("ch2_last_high", hi, 6);
    chk("ch2_last_pe", pe, 2);

    // ch3 boundary cases
    commit(3, 12, 0);
    wait_pend_clear(3, k);
    count(3, 24, hi, pe);
    chk("ch3_d0_high", hi, 0);
    chk("ch3_d0_pe", pe, 2);
    commit(3, 12, 12);
    wait_pend_clear(3, k);
    count(3, 24, hi, pe);
    chk("ch3_dp_high", hi, 24);
    commit(3, 1, 0);
    wait_pend_clear(3, k);
    count(3, 10, hi, pe);
    chk("ch3_p1_pe", pe, 10);
    commit(3, 0, 5);
    wait_pend_clear(3, k);
    count(3, 10, hi, pe);
    chk("ch3_p0_high", hi, 0);
    chk("ch3_p0_pe", pe, 0);

    // commit edge in the same cycle as ch0's wrap
    wait_pe(0);
    commit(0, 4, 1);
    chk("ch0_wrap_edge_pending", int'(pend_o[0]), 1);
    wait_pend_clear(0, k);
    chk("ch0_wrap_edge_delay", k, 10);
    count(0, 8, hi, pe);
    chk("ch0_p4_high", hi, 2);
    chk("ch0_p4_pe", pe, 2);

    // freeze for 5 cycles at the start of a period
    wait_pe(0);
    tick(1);
    enable_i = 1'b0;
    count(0, 5, hi, pe);
    chk("freeze_pwm_held", hi, 5);
    chk("freeze_no_pe", pe, 0);
    enable_i = 1'b1;
    k = 0;
    while (!pe_o[0] && k < 20) begin
      tick(1);
      k++;
    end
    chk("freeze_resume_to_pe", k, 3);

    // async reset mid-period with a pending pair
    commit(1, 7, 2);
    chk("rst_pending_before", int'(pend_o[1]), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_pwm", int'(pwm_o), 0);
    chk("rst_async_pending", int'(pend_o), 0);
    chk("rst_async_pe", int'(pe_o), 0);
    tick(2);
    rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      if ((|pwm_o) || (|pend_o) || (|pe_o)) bad++;
      tick(1);
    end
    chk("post_reset_idle", bad, 0);
    commit(2, 3, 1);
    tick(1);
    chk("post_reset_commit", int'(pwm_o[2]), 1);
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
